// File: rtl/des_decrypt_core_if.sv
// -----------------------------------------------------------------------------
// des_decrypt_core_if
//   Handshake bundle between a key/ciphertext source, the iterative DES core and
//   the plaintext sink.
//
//   in_valid  source -> core   ct/key valid
//   in_ready  core -> source   core idle, can accept
//   ct        source -> core   ciphertext, bit 1 (FIPS numbering) = bit 63
//   key       source -> core   key incl. parity bits (parity ignored)
//   out_valid core -> sink     pt valid
//   out_ready sink -> core     sink accepts pt
//   pt        core -> sink     plaintext, bit 1 = bit 63
//   busy      core -> monitor  Feistel rounds in progress
//   enc       source -> core   1 = encrypt, 0 = decrypt (only with DES_ENC_SEL_EN)
//
//   Optional feature macro: DES_ENC_SEL_EN adds the enc signal.
// -----------------------------------------------------------------------------
interface des_decrypt_core_if;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] ct;
  logic [63:0] key;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] pt;
  logic        busy;
`ifdef DES_ENC_SEL_EN
  logic        enc;

  modport master (output in_valid, ct, key, out_ready, enc,
                  input  in_ready, out_valid, pt, busy);
  modport slave  (input  in_valid, ct, key, out_ready, enc,
                  output in_ready, out_valid, pt, busy);
`else
  modport master (output in_valid, ct, key, out_ready,
                  input  in_ready, out_valid, pt, busy);
  modport slave  (input  in_valid, ct, key, out_ready,
                  output in_ready, out_valid, pt, busy);
`endif
endinterface

// File: rtl/des_decrypt_core.sv
// -----------------------------------------------------------------------------
// des_decrypt_core
//   Iterative DES decryption engine. IP, then 16 Feistel rounds with subkeys
//   K16..K1 produced on the fly by right-rotating C/D, then half swap and FP.
//   ROUNDS_PER_CLK rounds are unrolled per clock (1, 2, 4, 8 or 16).
//
//   Ports:
//     clk    system clock, rising edge
//     rst_n  asynchronous active-low reset
//     bus    des_decrypt_core_if.slave (in_valid/in_ready/ct/key,
//            out_valid/out_ready/pt, busy[, enc])
//
//   Optional feature macro: DES_ENC_SEL_EN -- adds bus.enc, sampled at accept;
//   enc=1 left-rotates the key schedule so the core encrypts (same latency).
//
//   Contains des_sbox (one DES S-box, selected by BOX) and the core itself.
// -----------------------------------------------------------------------------

// One DES S-box. Input bit a[5] is b1; row = {b1,b6}, column = b2..b5.
module des_sbox #(
  parameter int BOX = 1
) (
  input  logic [5:0] a,
  output logic [3:0] y
);
  // 64 nibbles per box, row-major, entry 0 in the top nibble.
  localparam logic [255:0] TBL =
    (BOX == 1) ? 256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D :
    (BOX == 2) ? 256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9 :
    (BOX == 3) ? 256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C :
    (BOX == 4) ? 256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E :
    (BOX == 5) ? 256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453 :
    (BOX == 6) ? 256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D :
    (BOX == 7) ? 256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C :
                 256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B;

  logic [5:0] idx;
  assign idx = {a[5], a[0], a[4:1]};
  // Entry idx sits at nibble (63 - idx) counting from the LSB end.
  assign y = TBL[{~idx, 2'b00} +: 4];
endmodule

module des_decrypt_core #(
  parameter int ROUNDS_PER_CLK = 1
) (
  input logic               clk,
  input logic               rst_n,
  des_decrypt_core_if.slave bus
);
  localparam int R = ROUNDS_PER_CLK;

  if (R != 1 && R != 2 && R != 4 && R != 8 && R != 16) begin : g_bad_rounds
    $error("des_decrypt_core: ROUNDS_PER_CLK must be 1, 2, 4, 8 or 16");
  end

  // Permutation tables, FIPS 46 1-based source bit numbers.
  localparam int IP_T [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
                               62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
                               57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3,
                               61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
  localparam int FP_T [64] = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
                               38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
                               36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
                               34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
  localparam int E_T  [48] = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13,
                               12,13,14,15,16,17, 16,17,18,19,20,21,
                               20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
  localparam int P_T  [32] = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
                               2,8,24,14,32,27,3,9,    19,13,30,6,22,11,4,25};
  localparam int PC1_T [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18,
                                10,2,59,51,43,35,27, 19,11,3,60,52,44,36,
                                63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                                14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
  localparam int PC2_T [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10,
                                23,19,12,4,26,8, 16,7,27,20,13,2,
                                41,52,31,37,47,55, 30,40,51,45,33,48,
                                44,49,39,56,34,53, 46,42,50,36,29,32};

  function automatic logic [63:0] ip_f(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 64; i++) y[63-i] = x[64-IP_T[i]];
    return y;
  endfunction

  function automatic logic [63:0] fp_f(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 64; i++) y[63-i] = x[64-FP_T[i]];
    return y;
  endfunction

  function automatic logic [47:0] e_f(input logic [31:0] x);
    logic [47:0] y;
    for (int i = 0; i < 48; i++) y[47-i] = x[32-E_T[i]];
    return y;
  endfunction

  function automatic logic [31:0] p_f(input logic [31:0] x);
    logic [31:0] y;
    for (int i = 0; i < 32; i++) y[31-i] = x[32-P_T[i]];
    return y;
  endfunction

  function automatic logic [55:0] pc1_f(input logic [63:0] x);
    logic [55:0] y;
    for (int i = 0; i < 56; i++) y[55-i] = x[64-PC1_T[i]];
    return y;
  endfunction

  function automatic logic [47:0] pc2_f(input logic [55:0] x);
    logic [47:0] y;
    for (int i = 0; i < 48; i++) y[47-i] = x[56-PC2_T[i]];
    return y;
  endfunction

  // Key-half rotation for round i. Decrypt walks the encrypt schedule
  // backwards: round 1 reuses PC1 as-is (total encrypt shift is 28).
  function automatic logic [27:0] rot28(input logic [27:0] x, input logic [4:0] i,
                                        input logic enc);
    logic       one;
    logic [1:0] amt;
    one = (i == 5'd2) || (i == 5'd9) || (i == 5'd16);
    if (enc)              amt = (one || i == 5'd1) ? 2'd1 : 2'd2;
    else if (i == 5'd1)   amt = 2'd0;
    else                  amt = one ? 2'd1 : 2'd2;
    case ({enc, amt})
      3'b001:  rot28 = {x[0], x[27:1]};
      3'b010:  rot28 = {x[1:0], x[27:2]};
      3'b101:  rot28 = {x[26:0], x[27]};
      3'b110:  rot28 = {x[25:0], x[27:26]};
      default: rot28 = x;
    endcase
  endfunction

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

  state_t      state;
  logic [4:0]  rnd;
  logic [31:0] l_q, r_q;
  logic [27:0] c_q, d_q;
  logic [63:0] pt_q;
  logic        in_ready_q, out_valid_q, busy_q;
  logic        enc_q;

  logic [63:0] ip_ct;
  logic [55:0] pc1_key;
  assign ip_ct   = ip_f(bus.ct);
  assign pc1_key = pc1_f(bus.key);

  // Combinational chain of R rounds starting at round rnd.
  logic [31:0] l_c [R+1];
  logic [31:0] r_c [R+1];
  logic [27:0] c_c [R+1];
  logic [27:0] d_c [R+1];

  assign l_c[0] = l_q;
  assign r_c[0] = r_q;
  assign c_c[0] = c_q;
  assign d_c[0] = d_q;

  for (genvar j = 0; j < R; j++) begin : g_rnd
    logic [4:0]  idx;
    logic [27:0] c_rot, d_rot;
    logic [47:0] xk;
    logic [31:0] s_out;

    assign idx   = rnd + 5'(j);
    assign c_rot = rot28(c_c[j], idx, enc_q);
    assign d_rot = rot28(d_c[j], idx, enc_q);
    assign xk    = e_f(r_c[j]) ^ pc2_f({c_rot, d_rot});

    for (genvar b = 0; b < 8; b++) begin : g_sbox
      des_sbox #(.BOX(b + 1)) u_sbox (
        .a (xk[47-6*b -: 6]),
        .y (s_out[31-4*b -: 4])
      );
    end

    assign l_c[j+1] = r_c[j];
    assign r_c[j+1] = l_c[j] ^ p_f(s_out);
    assign c_c[j+1] = c_rot;
    assign d_c[j+1] = d_rot;
  end

  logic last_step;
  assign last_step = ({1'b0, rnd} + 6'(R - 1)) == 6'd16;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rnd         <= '0;
      l_q         <= '0;
      r_q         <= '0;
      c_q         <= '0;
      d_q         <= '0;
      pt_q        <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      enc_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            l_q        <= ip_ct[63:32];
            r_q        <= ip_ct[31:0];
            c_q        <= pc1_key[55:28];
            d_q        <= pc1_key[27:0];
            rnd        <= 5'd1;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
`ifdef DES_ENC_SEL_EN
            enc_q      <= bus.enc;
`endif
            state      <= ROUND;
          end
        end
        ROUND: begin
          l_q <= l_c[R];
          r_q <= r_c[R];
          c_q <= c_c[R];
          d_q <= d_c[R];
          if (last_step) begin
            // Halves swapped into FP; counter parked at 0 so it never passes 16.
            pt_q        <= fp_f({r_c[R], l_c[R]});
            rnd         <= '0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b1;
            state       <= DONE;
          end else begin
            rnd <= rnd + 5'(R);
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.pt        = pt_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_des_decrypt_core.sv
// -----------------------------------------------------------------------------
// tb_des_decrypt_core
//   Directed bench for des_decrypt_core: one instance at ROUNDS_PER_CLK=1 and
//   one at ROUNDS_PER_CLK=4, driven through des_decrypt_core_if.
//   Latency is counted in clocks with the accept edge as clock 1, so the first
//   sample showing out_valid is at clock 16/R+1.
// -----------------------------------------------------------------------------
module tb_des_decrypt_core;
  logic clk;
  logic rst_n;

  des_decrypt_core_if b1 ();
  des_decrypt_core_if b4 ();

`ifdef DES_ENC_SEL_EN
  logic enc_mode;
  assign b1.enc = enc_mode;
  assign b4.enc = 1'b0;
`endif

  des_decrypt_core #(.ROUNDS_PER_CLK(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  des_decrypt_core #(.ROUNDS_PER_CLK(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [63:0] K1 = 64'h133457799BBCDFF1;
  localparam logic [63:0] C1 = 64'h85E813540F0AB405;
  localparam logic [63:0] P1 = 64'h0123456789ABCDEF;
  localparam logic [63:0] K2 = 64'h0E329232EA6D0D73;
  localparam logic [63:0] C2 = 64'h0000000000000000;
  localparam logic [63:0] P2 = 64'h8787878787878787;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one block on b1, wait for out_valid (bounded). lat = -1 on timeout.
  // fb = {busy, in_ready} on the first sample after the accept edge.
  task automatic xfer1(input logic [63:0] k, input logic [63:0] c,
                       output logic [63:0] res, output int lat, output logic [1:0] fb);
    @(negedge clk);
    b1.key = k; b1.ct = c; b1.in_valid = 1'b1; b1.out_ready = 1'b0;
    lat = -1; fb = 2'bxx; res = '0;
    for (int i = 0; i < 40 && !b1.in_ready; i++) @(negedge clk);
    @(posedge clk);
    #1;
    b1.in_valid = 1'b0; b1.key = ~k; b1.ct = ~c;
    lat = 1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); lat++;
      @(negedge clk);
      if (i == 0) fb = {b1.busy, b1.in_ready};
      if (b1.out_valid) break;
    end
    if (!b1.out_valid) lat = -1;
    res = b1.pt;
  endtask

  // Called at a negedge with out_valid high; returns at the negedge after exit.
  task automatic release1();
    b1.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b1.out_ready = 1'b0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] res;
    int          lat;
    logic [1:0]  fb;

    b1.in_valid = 1'b0; b1.out_ready = 1'b0; b1.ct = '0; b1.key = '0;
    b4.in_valid = 1'b0; b4.out_ready = 1'b0; b4.ct = '0; b4.key = '0;
`ifdef DES_ENC_SEL_EN
    enc_mode = 1'b0;
`endif
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state of both instances
    chk("rst_in_ready",   64'(b1.in_ready),  64'd1);
    chk("rst_out_valid",  64'(b1.out_valid), 64'd0);
    chk("rst_busy",       64'(b1.busy),      64'd0);
    chk("rst_pt",         b1.pt,             64'd0);
    chk("rst4_in_ready",  64'(b4.in_ready),  64'd1);
    chk("rst4_out_valid", 64'(b4.out_valid), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // T1: textbook vector, latency and in-flight flags
    xfer1(K1, C1, res, lat, fb);
    chk("t1_pt",  res,         P1);
    chk("t1_lat", 64'(lat),    64'd17);
    chk("t1_flags_running", 64'(fb), 64'b10);
    release1();
    chk("t1_in_ready_after",  64'(b1.in_ready),  64'd1);
    chk("t1_out_valid_after", 64'(b1.out_valid), 64'd0);

    // All-zero key and all-one key boundaries
    xfer1(64'h0, 64'h8CA64DE9C1B123A7, res, lat, fb);
    chk("zero_key_pt", res, 64'h0);
    release1();
    xfer1(64'hFFFFFFFFFFFFFFFF, 64'h7359B2163E4EDC58, res, lat, fb);
    chk("ones_key_pt", res, 64'hFFFFFFFFFFFFFFFF);
    release1();

    // T3: back-pressure for 10 cycles with the next block (T2) pending
    xfer1(K1, C1, res, lat, fb);
    chk("t3_pt_first", res, P1);
    b1.key = K2; b1.ct = C2; b1.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("t3_stall_pt",        b1.pt,             P1);
      chk("t3_stall_out_valid", 64'(b1.out_valid), 64'd1);
      chk("t3_stall_in_ready",  64'(b1.in_ready),  64'd0);
      @(negedge clk);
    end
    b1.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b1.out_ready = 1'b0;
    chk("t3_release_in_ready",  64'(b1.in_ready),  64'd1);
    chk("t3_release_out_valid", 64'(b1.out_valid), 64'd0);
    @(posedge clk);
    #1 b1.in_valid = 1'b0; b1.key = '0; b1.ct = '1;
    @(negedge clk);
    chk("t3_resume_busy", 64'(b1.busy), 64'd1);
    for (int i = 0; i < 40 && !b1.out_valid; i++) @(negedge clk);
    chk("t2_out_valid", 64'(b1.out_valid), 64'd1);
    chk("t2_pt",        b1.pt,             P2);
    release1();

    // T4: asynchronous reset in the middle of the rounds
    @(negedge clk);
    b1.key = K1; b1.ct = C1; b1.in_valid = 1'b1;
    @(posedge clk);
    #1 b1.in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t4_in_ready",  64'(b1.in_ready),  64'd1);
    chk("t4_out_valid", 64'(b1.out_valid), 64'd0);
    chk("t4_busy",      64'(b1.busy),      64'd0);
    chk("t4_pt",        b1.pt,             64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    xfer1(K1, C1, res, lat, fb);
    chk("t4_next_pt",  res,      P1);
    chk("t4_next_lat", 64'(lat), 64'd17);
    release1();

    // T5: four rounds per clock, in_valid held high throughout
    @(negedge clk);
    b4.key = K1; b4.ct = C1; b4.in_valid = 1'b1; b4.out_ready = 1'b0;
    chk("t5_in_ready_idle", 64'(b4.in_ready), 64'd1);
    @(posedge clk);
    lat = 1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); lat++;
      @(negedge clk);
      if (i == 0) chk("t5_flags_running", 64'({b4.busy, b4.in_ready}), 64'b10);
      if (b4.out_valid) break;
    end
    if (!b4.out_valid) lat = -1;
    chk("t5_lat", 64'(lat), 64'd5);
    chk("t5_pt",  b4.pt,    P1);
    @(negedge clk);
    chk("t5_no_accept_in_done", 64'({b4.busy, b4.in_ready, b4.out_valid}), 64'b001);
    b4.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b4.out_ready = 1'b0;
    chk("t5_exit_flags", 64'({b4.busy, b4.in_ready, b4.out_valid}), 64'b010);
    @(posedge clk);
    @(negedge clk);
    b4.in_valid = 1'b0;
    chk("t5_reaccept_busy", 64'(b4.busy), 64'd1);
    for (int i = 0; i < 20 && !b4.out_valid; i++) @(negedge clk);
    chk("t5_second_pt", b4.pt, P1);
    b4.out_ready = 1'b1;
    @(negedge clk);
    b4.out_ready = 1'b0;

`ifdef DES_ENC_SEL_EN
    // T6: encrypt mode and encrypt->decrypt round trips
    enc_mode = 1'b1;
    xfer1(K1, P1, res, lat, fb);
    chk("t6_enc_ct",  res,      C1);
    chk("t6_enc_lat", 64'(lat), 64'd17);
    release1();
    for (int n = 0; n < 1000; n++) begin
      logic [63:0] k, p, c, q;
      k = {$urandom, $urandom};
      p = {$urandom, $urandom};
      enc_mode = 1'b1;
      xfer1(k, p, c, lat, fb);
      release1();
      enc_mode = 1'b0;
      xfer1(k, c, q, lat, fb);
      release1();
      chk("t6_round_trip", q, p);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
